// File: rtl/madd_err_sweep.sv
// Exhaustive sweep tester for an external 3x3+3 unsigned multiply-add block.
// Drives every 9-bit vector, compares the result to a*b+c and collects error stats.
// Ports: clk/rst_n; start/abort control; dut_pi/dut_po to the block under test;
//        busy/done status; err_cnt/max_err/sum_err/first_err_vec/first_err_valid.
module madd_err_sweep #(
  parameter int unsigned SETTLE = 0  // extra wait cycles per vector (0..7)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  dut_po,
  output logic [8:0]  dut_pi,
  output logic        busy,
  output logic        done,
  output logic [9:0]  err_cnt,
  output logic [5:0]  max_err,
  output logic [14:0] sum_err,
  output logic [8:0]  first_err_vec,
  output logic        first_err_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] SETTLE_L = 3'(SETTLE);

  state_t      state_q, state_d;
  logic [8:0]  v_q, v_d;
  logic [2:0]  settle_q, settle_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [9:0]  err_cnt_q, err_cnt_d;
  logic [5:0]  max_err_q, max_err_d;
  logic [14:0] sum_err_q, sum_err_d;
  logic [8:0]  fvec_q, fvec_d;
  logic        fvld_q, fvld_d;

  // Golden result and absolute error for the vector currently driven.
  logic [5:0] golden;
  logic [5:0] err;
  logic       sample;

  always_comb begin
    golden = ({3'b000, v_q[2:0]} * {3'b000, v_q[5:3]}) + {3'b000, v_q[8:6]};
    err    = (golden >= dut_po) ? (golden - dut_po) : (dut_po - golden);
    // Only the last cycle of a vector's slot is sampled, so a slow block
    // has SETTLE extra cycles to produce its answer.
    sample = (state_q == RUN) && (settle_q == SETTLE_L);
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_cnt_d = err_cnt_q;
    max_err_d = max_err_q;
    sum_err_d = sum_err_q;
    fvec_d    = fvec_q;
    fvld_d    = fvld_q;

    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          // Abort dominates start; statistics are kept for inspection.
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          v_d       = '0;
          settle_d  = '0;
          err_cnt_d = '0;
          max_err_d = '0;
          sum_err_d = '0;
          fvec_d    = '0;
          fvld_d    = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          // Partial statistics survive an abort; the vector index does not.
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          v_d      = '0;
          settle_d = '0;
        end else if (sample) begin
          settle_d  = '0;
          err_cnt_d = err_cnt_q + 10'(err != 6'd0);
          sum_err_d = sum_err_q + 15'(err);
          if (err > max_err_q) begin
            max_err_d = err;
          end
          if (!fvld_q && (err != 6'd0)) begin
            fvec_d = v_q;
            fvld_d = 1'b1;
          end
          if (v_q == 9'd511) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            v_d     = '0;
          end else begin
            v_d = v_q + 9'd1;
          end
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        v_d      = '0;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      v_q       <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= '0;
      max_err_q <= '0;
      sum_err_q <= '0;
      fvec_q    <= '0;
      fvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
      max_err_q <= max_err_d;
      sum_err_q <= sum_err_d;
      fvec_q    <= fvec_d;
      fvld_q    <= fvld_d;
    end
  end

  assign dut_pi          = v_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_cnt         = err_cnt_q;
  assign max_err         = max_err_q;
  assign sum_err         = sum_err_q;
  assign first_err_vec   = fvec_q;
  assign first_err_valid = fvld_q;

endmodule
